// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

    // Major opcodes returned to the control unit.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // PC source select encodings.
    localparam logic [1:0] PC_SEL_INC    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;
    localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

    // addi x0,x0,0, substituted for an aborted fetch.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Redirect target selection and word-alignment check for the fetch stage.
module pc_next_calc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_old_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_res_i,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    // Pick the target; the reserved encoding behaves as sequential pc+4.
    always_comb begin
        target_o = pc_i + XLEN'(4);
        case (pc_sel_i)
            PC_SEL_BRANCH: target_o = pc_old_i + imm_i;
            PC_SEL_JALR:   target_o = alu_res_i & ~XLEN'(1);
            default:       target_o = pc_i + XLEN'(4);
        endcase
    end

    assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, IR and pc_old, handshakes with imem.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_RESET = '0,
    parameter int unsigned      TIMEOUT  = 16,
    parameter logic [31:0]      NOP_INSN = fetch_unit_pkg::NOP_INSN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            ir_write_i,
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_res_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_ack_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_old_o,
    output logic [31:0]     ir_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            fetch_busy_o,
    output logic            misalign_err_o,
    output logic            fetch_err_o,
    output logic            protocol_err_o
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    fetch_state_e    state_q;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] pc_q, pc_old_q, imem_addr_q;
    logic [31:0]     ir_q;
    logic            imem_req_q, busy_q, pend_inc_q;
    logic            misalign_err_q, fetch_err_q, protocol_err_q;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            sel_redirect;
    logic            strobe;
    logic            fetch_end;

    pc_next_calc #(
        .XLEN(XLEN)
    ) u_pc_next_calc (
        .pc_sel_i    (pc_sel_i),
        .pc_i        (pc_q),
        .pc_old_i    (pc_old_q),
        .imm_i       (imm_i),
        .alu_res_i   (alu_res_i),
        .target_o    (target),
        .misaligned_o(misaligned)
    );

    assign sel_redirect = (pc_sel_i == PC_SEL_BRANCH) || (pc_sel_i == PC_SEL_JALR);
    assign strobe       = pc_write_i || ir_write_i;
    // Either the memory answered or the wait budget is spent.
    assign fetch_end    = imem_ack_i || (cnt_q == CntLast);

    // Fetch FSM with all architectural state and outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            pc_q           <= PC_RESET;
            pc_old_q       <= '0;
            ir_q           <= '0;
            imem_addr_q    <= '0;
            imem_req_q     <= 1'b0;
            busy_q         <= 1'b0;
            pend_inc_q     <= 1'b0;
            misalign_err_q <= 1'b0;
            fetch_err_q    <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ir_write_i) begin
                        imem_addr_q <= pc_q;
                        imem_req_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        // A redirect cannot share a cycle with a fetch; drop it.
                        pend_inc_q  <= pc_write_i && !sel_redirect;
                        if (pc_write_i && sel_redirect) begin
                            protocol_err_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end else if (pc_write_i) begin
                        if (misaligned) begin
                            misalign_err_q <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
                    end
                end
                StWait: begin
                    if (strobe) begin
                        protocol_err_q <= 1'b1;
                    end
                    if (fetch_end) begin
                        ir_q       <= imem_ack_i ? imem_rdata_i : NOP_INSN;
                        pc_old_q   <= imem_addr_q;
                        imem_req_q <= 1'b0;
                        if (!imem_ack_i) begin
                            fetch_err_q <= 1'b1;
                        end
                        if (pend_inc_q) begin
                            pc_q <= pc_q + XLEN'(4);
                        end
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (strobe) begin
                        protocol_err_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req_o     = imem_req_q;
    assign imem_addr_o    = imem_addr_q;
    assign pc_o           = pc_q;
    assign pc_old_o       = pc_old_q;
    assign ir_o           = ir_q;
    assign opcode_o       = ir_q[6:0];
    assign funct3_o       = ir_q[14:12];
    assign funct7_o       = ir_q[31:25];
    assign fetch_busy_o   = busy_q;
    assign misalign_err_o = misalign_err_q;
    assign fetch_err_o    = fetch_err_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, redirect, misalign, timeout, reset, protocol.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0;
    logic        ir_write = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] imm = '0;
    logic [31:0] alu_res = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] pc, pc_old, ir;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        fetch_busy, misalign_err, fetch_err, protocol_err;

    int checks = 0;
    int failures = 0;

    fetch_unit #(
        .XLEN    (32),
        .PC_RESET(32'h0000_0000),
        .TIMEOUT (16),
        .NOP_INSN(32'h0000_0013)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_write_i    (pc_write),
        .ir_write_i    (ir_write),
        .pc_sel_i      (pc_sel),
        .imm_i         (imm),
        .alu_res_i     (alu_res),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .imem_ack_i    (imem_ack),
        .pc_o          (pc),
        .pc_old_o      (pc_old),
        .ir_o          (ir),
        .opcode_o      (opcode),
        .funct3_o      (funct3),
        .funct7_o      (funct7),
        .fetch_busy_o  (fetch_busy),
        .misalign_err_o(misalign_err),
        .fetch_err_o   (fetch_err),
        .protocol_err_o(protocol_err)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(input logic pw, input logic [1:0] sel);
        ir_write = 1'b1;
        pc_write = pw;
        pc_sel   = sel;
        tick();
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 2'b00;
    endtask

    task automatic give_ack(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (pc_old !== 32'h0) begin failures++; $display("FAIL reset_pc_old got %h want %h", pc_old, 32'h0); end
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got %h want %h", ir, 32'h0); end
        checks++; if ({imem_req, fetch_busy} !== 2'b00) begin failures++; $display("FAIL reset_req_busy got %b want 00", {imem_req, fetch_busy}); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'h0); end
        checks++; if ({misalign_err, fetch_err, protocol_err} !== 3'b000) begin failures++; $display("FAIL reset_errs got %b want 000", {misalign_err, fetch_err, protocol_err}); end
    endtask

    task automatic test_basic_fetch();
        start_fetch(1'b1, 2'b00);
        checks++; if ({imem_req, fetch_busy} !== 2'b11) begin failures++; $display("FAIL bf_req_busy got %b want 11", {imem_req, fetch_busy}); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL bf_addr got %h want %h", imem_addr, 32'h0); end
        tick();
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bf_req_held got %b want 1", imem_req); end
        give_ack(32'h0050_0093);
        checks++; if (ir !== 32'h0050_0093) begin failures++; $display("FAIL bf_ir got %h want %h", ir, 32'h0050_0093); end
        checks++; if (opcode !== 7'b0010011) begin failures++; $display("FAIL bf_opcode got %b want 0010011", opcode); end
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL bf_pc got %h want %h", pc, 32'h4); end
        checks++; if (pc_old !== 32'h0) begin failures++; $display("FAIL bf_pc_old got %h want %h", pc_old, 32'h0); end
        checks++; if ({imem_req, fetch_busy} !== 2'b01) begin failures++; $display("FAIL bf_done got %b want 01", {imem_req, fetch_busy}); end
        tick();
        checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL bf_busy_fall got %b want 0", fetch_busy); end
    endtask

    task automatic test_redirect();
        start_fetch(1'b1, 2'b00);
        give_ack(32'h0000_0013);
        tick();
        start_fetch(1'b0, 2'b00);
        give_ack(32'h0000_0013);
        tick();
        checks++; if (pc_old !== 32'h8) begin failures++; $display("FAIL rd_pc_old got %h want %h", pc_old, 32'h8); end
        checks++; if (pc !== 32'h8) begin failures++; $display("FAIL rd_pc_hold got %h want %h", pc, 32'h8); end
        pc_write = 1'b1; pc_sel = 2'b01; imm = 32'h10;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h18) begin failures++; $display("FAIL rd_branch got %h want %h", pc, 32'h18); end
        pc_write = 1'b1; pc_sel = 2'b10; alu_res = 32'h21;
        tick();
        pc_write = 1'b0; pc_sel = 2'b00;
        checks++; if (pc !== 32'h20) begin failures++; $display("FAIL rd_jalr got %h want %h", pc, 32'h20); end
        checks++; if ({misalign_err, protocol_err} !== 2'b00) begin failures++; $display("FAIL rd_errs got %b want 00", {misalign_err, protocol_err}); end
    endtask

    task automatic test_misalign();
        pc_write = 1'b1; pc_sel = 2'b01; imm = 32'h6;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h20) begin failures++; $display("FAIL ma_pc got %h want %h", pc, 32'h20); end
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL ma_flag got %b want 1", misalign_err); end
        pc_write = 1'b1; pc_sel = 2'b10; alu_res = 32'h22;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h20) begin failures++; $display("FAIL ma_jalr_pc got %h want %h", pc, 32'h20); end
        tick(); tick(); tick();
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL ma_sticky got %b want 1", misalign_err); end
        pc_write = 1'b1; pc_sel = 2'b11;
        tick();
        pc_write = 1'b0; pc_sel = 2'b00;
        checks++; if (pc !== 32'h24) begin failures++; $display("FAIL ma_rsvd_sel got %h want %h", pc, 32'h24); end
    endtask

    task automatic test_timeout();
        start_fetch(1'b1, 2'b00);
        for (int i = 0; i < 15; i++) tick();
        checks++; if ({imem_req, fetch_err} !== 2'b10) begin failures++; $display("FAIL to_early got %b want 10", {imem_req, fetch_err}); end
        checks++; if (imem_addr !== 32'h24) begin failures++; $display("FAIL to_addr got %h want %h", imem_addr, 32'h24); end
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_req_drop got %b want 0", imem_req); end
        checks++; if (ir !== 32'h0000_0013) begin failures++; $display("FAIL to_ir got %h want %h", ir, 32'h0000_0013); end
        checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL to_flag got %b want 1", fetch_err); end
        checks++; if (pc !== 32'h28) begin failures++; $display("FAIL to_pc got %h want %h", pc, 32'h28); end
        checks++; if (pc_old !== 32'h24) begin failures++; $display("FAIL to_pc_old got %h want %h", pc_old, 32'h24); end
        tick();
        checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL to_busy got %b want 0", fetch_busy); end
    endtask

    task automatic test_reset_mid_fetch();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_fetch(1'b1, 2'b00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({imem_req, fetch_busy} !== 2'b00) begin failures++; $display("FAIL rm_req_busy got %b want 00", {imem_req, fetch_busy}); end
        tick();
        tick();
        give_ack(32'hdead_beef);
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL rm_ir got %h want %h", ir, 32'h0); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rm_pc got %h want %h", pc, 32'h0); end
        checks++; if (pc_old !== 32'h0) begin failures++; $display("FAIL rm_pc_old got %h want %h", pc_old, 32'h0); end
        checks++; if ({imem_req, fetch_busy} !== 2'b00) begin failures++; $display("FAIL rm_late_ack got %b want 00", {imem_req, fetch_busy}); end
        checks++; if ({misalign_err, fetch_err} !== 2'b00) begin failures++; $display("FAIL rm_errs got %b want 00", {misalign_err, fetch_err}); end
    endtask

    task automatic test_protocol();
        start_fetch(1'b0, 2'b00);
        ir_write = 1'b1; pc_write = 1'b1; pc_sel = 2'b01; imm = 32'h40;
        tick();
        ir_write = 1'b0; pc_write = 1'b0; pc_sel = 2'b00;
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL pr_wait_flag got %b want 1", protocol_err); end
        checks++; if ({imem_req, pc} !== {1'b1, 32'h0}) begin failures++; $display("FAIL pr_wait_ignored got %h want %h", {imem_req, pc}, {1'b1, 32'h0}); end
        give_ack(32'h40b5_0533);
        checks++; if (ir !== 32'h40b5_0533) begin failures++; $display("FAIL pr_ir got %h want %h", ir, 32'h40b5_0533); end
        checks++; if ({funct7, funct3, opcode} !== {7'h20, 3'h0, 7'b0110011}) begin failures++; $display("FAIL pr_fields got %h want %h", {funct7, funct3, opcode}, {7'h20, 3'h0, 7'b0110011}); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL pr_pc got %h want %h", pc, 32'h0); end
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        checks++; if ({imem_req, fetch_busy} !== 2'b00) begin failures++; $display("FAIL pr_done_strobe got %b want 00", {imem_req, fetch_busy}); end
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL pr_no_refetch got %b want 0", imem_req); end

        // Fetch combined with a branch redirect in IDLE: flag it, fetch anyway.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ir_write = 1'b1; pc_write = 1'b1; pc_sel = 2'b01; imm = 32'h10;
        tick();
        ir_write = 1'b0; pc_write = 1'b0; pc_sel = 2'b00;
        checks++; if ({protocol_err, imem_req} !== 2'b11) begin failures++; $display("FAIL pr_combo got %b want 11", {protocol_err, imem_req}); end
        give_ack(32'h00a5_f513);
        checks++; if ({funct3, opcode} !== {3'h7, 7'b0010011}) begin failures++; $display("FAIL pr_combo_fields got %h want %h", {funct3, opcode}, {3'h7, 7'b0010011}); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL pr_combo_pc got %h want %h", pc, 32'h0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect();
        test_misalign();
        test_timeout();
        test_reset_mid_fetch();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
